// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller: access sizes, FSM
// state encoding and the byte-lane mask helper.
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Little-endian byte enables for an access of the given size at byte offset off.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            SIZE_BYTE: m = 4'b0001 << off;
            SIZE_HALF: m = off[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: m = 4'b1111;
            default:   m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 storage split into four byte-lane arrays, each with its own
// write enable; cleared on reset, combinational read, word-0 tap.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic [31:0]      tap
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        lane_mem[i] <= '0;
                    end
                end else if (we && be[gi]) begin
                    lane_mem[idx] <= wdata[8*gi +: 8];
                end
            end

            assign rdata[8*gi +: 8] = lane_mem[idx];
            assign tap[8*gi +: 8]   = lane_mem[0];
        end
    endgenerate

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte/half/word data memory with REQ/READY handshake, programmable wait
// states, alignment/range checking and sign/zero-extended loads.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 2,
    parameter int TEST_W      = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ,
    input  logic              WE,
    input  logic [1:0]        SIZE,
    input  logic              SIGNED_LD,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] WD,
    output logic [DATA_W-1:0] RD,
    output logic              READY,
    output logic              ERR,
    output logic [TEST_W-1:0] TEST_VALUE
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg;
    logic              we_reg, signed_reg, err_reg;
    logic [1:0]        size_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wd_reg, rd_reg;

    logic              access;
    logic              bad_size, misalign, out_range, req_err, mem_we;
    logic [3:0]        be;
    logic [31:0]       wdata_rep, rdata, tap, ld_shift, ld_val;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        access     = 1'b0;
        case (state_reg)
            IDLE: if (REQ) state_next = WAIT;
            WAIT: if (cnt_reg == 4'd0) begin
                access     = 1'b1;
                state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // All checks run on the latched request, never on the live bus.
    assign bad_size  = (size_reg == 2'b11);
    assign misalign  = ((size_reg == SIZE_HALF) && addr_reg[0]) ||
                       ((size_reg == SIZE_WORD) && (addr_reg[1:0] != 2'b00));
    assign out_range = (addr_reg[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH));
    assign req_err   = bad_size | misalign | out_range;

    assign be     = lane_mask(size_reg, addr_reg[1:0]);
    assign mem_we = access && we_reg && !req_err;

    always_comb begin
        wdata_rep = wd_reg;
        case (size_reg)
            SIZE_BYTE: wdata_rep = {4{wd_reg[7:0]}};
            SIZE_HALF: wdata_rep = {2{wd_reg[15:0]}};
            default:   wdata_rep = wd_reg;
        endcase
    end

    assign ld_shift = rdata >> {addr_reg[1:0], 3'b000};

    always_comb begin
        ld_val = rdata;
        case (size_reg)
            SIZE_BYTE: ld_val = {{24{signed_reg & ld_shift[7]}}, ld_shift[7:0]};
            SIZE_HALF: ld_val = {{16{signed_reg & ld_shift[15]}}, ld_shift[15:0]};
            default:   ld_val = rdata;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_reg    <= '0;
            we_reg     <= 1'b0;
            size_reg   <= SIZE_BYTE;
            signed_reg <= 1'b0;
            addr_reg   <= '0;
            wd_reg     <= '0;
            rd_reg     <= '0;
            err_reg    <= 1'b0;
        end else begin
            if (state_reg == IDLE && REQ) begin
                we_reg     <= WE;
                size_reg   <= SIZE;
                signed_reg <= SIGNED_LD;
                addr_reg   <= ADDR;
                wd_reg     <= WD;
                cnt_reg    <= 4'(WAIT_STATES);
            end else if (state_reg == WAIT && cnt_reg != 4'd0) begin
                cnt_reg <= cnt_reg - 4'd1;
            end
            if (access) begin
                err_reg <= req_err;
                if (req_err)      rd_reg <= '0;
                else if (!we_reg) rd_reg <= ld_val;
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .CLK   (CLK),
        .RST   (RST),
        .we    (mem_we),
        .be    (be),
        .idx   (addr_reg[IDX_W+1:2]),
        .wdata (wdata_rep),
        .rdata (rdata),
        .tap   (tap)
    );

    assign RD         = rd_reg;
    assign READY      = (state_reg == RESP);
    assign ERR        = (state_reg == RESP) && err_reg;
    assign TEST_VALUE = TEST_W'(tap);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (2 and 0 wait states) sharing the
// request bus, table-driven transactions plus reset and REQ-toggle sequences.
module tb_data_mem_ctrl;

    localparam int DEPTH = 256;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        req2 = 1'b0, req0 = 1'b0;
    logic        WE = 1'b0, SIGNED_LD = 1'b0;
    logic [1:0]  SIZE = 2'b00;
    logic [31:0] ADDR = '0, WD = '0;

    logic [31:0] rd2, rd0;
    logic        ready2, ready0, err2, err0;
    logic [15:0] tv2, tv0;

    logic        sel = 1'b0;
    logic [31:0] rd_s;
    logic        ready_s, err_s;
    logic [15:0] tv_s;
    int          lat_exp;

    assign rd_s    = sel ? rd0 : rd2;
    assign ready_s = sel ? ready0 : ready2;
    assign err_s   = sel ? err0 : err2;
    assign tv_s    = sel ? tv0 : tv2;
    assign lat_exp = sel ? 2 : 4;

    always #5 CLK = ~CLK;

    data_mem_ctrl #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .WAIT_STATES(2), .TEST_W(16)) dut (
        .CLK(CLK), .RST(RST), .REQ(req2), .WE(WE), .SIZE(SIZE), .SIGNED_LD(SIGNED_LD),
        .ADDR(ADDR), .WD(WD), .RD(rd2), .READY(ready2), .ERR(err2), .TEST_VALUE(tv2)
    );

    data_mem_ctrl #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .WAIT_STATES(0), .TEST_W(16)) dut0 (
        .CLK(CLK), .RST(RST), .REQ(req0), .WE(WE), .SIZE(SIZE), .SIGNED_LD(SIGNED_LD),
        .ADDR(ADDR), .WD(WD), .RD(rd0), .READY(ready0), .ERR(err0), .TEST_VALUE(tv0)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        logic        chk_rd;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic        chk_rd;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_err, input logic chk_rd);
        vec_t v;
        v.name = name; v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wd = wd;
        v.exp_rd = exp_rd; v.exp_err = exp_err; v.chk_rd = chk_rd;
        vecs.push_back(v);
    endtask

    // One request on the selected instance; ends one edge after READY, back in IDLE.
    task automatic txn(input string name, input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_err, input logic chk_rd);
        exp_t e;
        int   cyc;
        logic got;
        e.rd = exp_rd; e.err = exp_err; e.chk_rd = chk_rd;
        sb_q.push_back(e);
        @(negedge CLK);
        WE = we; SIZE = size; SIGNED_LD = sgn; ADDR = addr; WD = wd;
        if (sel) req0 = 1'b1; else req2 = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(posedge CLK);
            #1;
            cyc++;
            got = ready_s;
        end
        req0 = 1'b0;
        req2 = 1'b0;
        e = sb_q.pop_front();
        check({name, " ready"}, 32'(got), 32'd1);
        check({name, " latency"}, cyc, lat_exp);
        check({name, " err"}, 32'(err_s), 32'(e.err));
        if (e.chk_rd) check({name, " rd"}, rd_s, e.rd);
        $display("txn %-14s ws=%0d we=%0d size=%0d sgn=%0d addr=0x%08h wd=0x%08h rd=0x%08h err=%0d cycles=%0d",
                 name, sel ? 0 : 2, we, size, sgn, addr, wd, rd_s, err_s, cyc);
        @(posedge CLK);
    endtask

    task automatic run_table();
        foreach (vecs[i]) begin
            txn(vecs[i].name, vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr,
                vecs[i].wd, vecs[i].exp_rd, vecs[i].exp_err, vecs[i].chk_rd);
        end
        #1;
        check("tap after table", 32'(tv_s), 32'h3344);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int fires;
        logic got;

        add("sw beef",    1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0, 0);
        add("lw beef",    0, 2'b10, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0, 1);
        add("sb 80",      1, 2'b00, 0, 32'h21,  32'hAAAAAA80, 32'h0,        0, 0);
        add("lb 80",      0, 2'b00, 1, 32'h21,  32'h0,        32'hFFFFFF80, 0, 1);
        add("lbu 80",     0, 2'b00, 0, 32'h21,  32'h0,        32'h00000080, 0, 1);
        add("lw 20",      0, 2'b10, 0, 32'h20,  32'h0,        32'h00008000, 0, 1);
        add("sh beef",    1, 2'b01, 0, 32'h32,  32'h1234BEEF, 32'h0,        0, 0);
        add("lh beef",    0, 2'b01, 1, 32'h32,  32'h0,        32'hFFFFBEEF, 0, 1);
        add("lhu beef",   0, 2'b01, 0, 32'h32,  32'h0,        32'h0000BEEF, 0, 1);
        add("lw 30",      0, 2'b10, 0, 32'h30,  32'h0,        32'hBEEF0000, 0, 1);
        add("sw w0",      1, 2'b10, 0, 32'h0,   32'h11223344, 32'h0,        0, 0);
        add("sw w1",      1, 2'b10, 0, 32'h4,   32'h55667788, 32'h0,        0, 0);
        add("lw w1",      0, 2'b10, 0, 32'h4,   32'h0,        32'h55667788, 0, 1);
        add("sh mis",     1, 2'b01, 0, 32'h1,   32'hFFFFFFFF, 32'h0,        1, 1);
        add("sw mis",     1, 2'b10, 0, 32'h6,   32'hFFFFFFFF, 32'h0,        1, 1);
        add("lw w1b",     0, 2'b10, 0, 32'h4,   32'h0,        32'h55667788, 0, 1);
        add("lw range",   0, 2'b10, 0, 32'h400, 32'h0,        32'h0,        1, 1);
        add("sw range",   1, 2'b10, 0, 32'h400, 32'hFFFFFFFF, 32'h0,        1, 1);
        add("lw w1c",     0, 2'b10, 0, 32'h4,   32'h0,        32'h55667788, 0, 1);
        add("ld size3",   0, 2'b11, 0, 32'h8,   32'h0,        32'h0,        1, 1);
        add("st size3",   1, 2'b11, 0, 32'h0,   32'hFFFFFFFF, 32'h0,        1, 1);
        add("lw w0",      0, 2'b10, 0, 32'h0,   32'h0,        32'h11223344, 0, 1);
        add("lw w1d",     0, 2'b10, 0, 32'h4,   32'h0,        32'h55667788, 0, 1);
        add("lb 3",       0, 2'b00, 1, 32'h3,   32'h0,        32'h00000011, 0, 1);
        add("lh 2",       0, 2'b01, 1, 32'h2,   32'h0,        32'h00001122, 0, 1);
        add("lbu 7",      0, 2'b00, 0, 32'h7,   32'h0,        32'h00000055, 0, 1);
        add("lb 4",       0, 2'b00, 1, 32'h4,   32'h0,        32'hFFFFFF88, 0, 1);
        add("lhu 4",      0, 2'b01, 0, 32'h4,   32'h0,        32'h00007788, 0, 1);
        add("lh 6",       0, 2'b01, 1, 32'h6,   32'h0,        32'h00005566, 0, 1);
        add("lw top0",    0, 2'b10, 0, 32'h3FC, 32'h0,        32'h0,        0, 1);
        add("sw top",     1, 2'b10, 0, 32'h3FC, 32'hCAFEF00D, 32'h0,        0, 0);
        add("lw top",     0, 2'b10, 0, 32'h3FC, 32'h0,        32'hCAFEF00D, 0, 1);

        // Outputs while held in reset
        #12;
        check("rst rd",    rd2,          32'h0);
        check("rst ready", 32'(ready2),  32'h0);
        check("rst err",   32'(err2),    32'h0);
        check("rst tap",   32'(tv2),     32'h0);
        check("rst ready0", 32'(ready0), 32'h0);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);

        // Reset aborts an in-flight store and clears memory
        sel = 1'b0;
        txn("sw pre0", 1, 2'b10, 0, 32'h0,  32'hA5A5A5A5, 32'h0, 0, 0);
        #1;
        check("tap pre", 32'(tv2), 32'hA5A5);
        txn("sw pre40", 1, 2'b10, 0, 32'h40, 32'h01020304, 32'h0, 0, 0);
        @(negedge CLK);
        WE = 1'b1; SIZE = 2'b10; ADDR = 32'h44; WD = 32'h99999999; req2 = 1'b1;
        @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        req2 = 1'b0;
        check("midrst ready", 32'(ready2), 32'h0);
        check("midrst tap",   32'(tv2),    32'h0);
        check("midrst rd",    rd2,         32'h0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        fires = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            #1;
            if (ready2) fires++;
        end
        check("postrst no ready", fires, 0);
        $display("txn %-14s ws=2 ready_pulses=%0d tap=0x%04h", "reset abort", fires, tv2);
        txn("lw rst0",  0, 2'b10, 0, 32'h0,  32'h0, 32'h0, 0, 1);
        txn("lw rst40", 0, 2'b10, 0, 32'h40, 32'h0, 32'h0, 0, 1);
        txn("lw rst44", 0, 2'b10, 0, 32'h44, 32'h0, 32'h0, 0, 1);

        run_table();

        // REQ toggling during WAIT must neither disturb nor queue
        txn("sw w1 seed", 1, 2'b10, 0, 32'h4, 32'h77777777, 32'h0, 0, 0);
        @(negedge CLK);
        WE = 1'b1; SIZE = 2'b10; SIGNED_LD = 1'b0; ADDR = 32'h0; WD = 32'h00001234; req2 = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(posedge CLK);
            #1;
            cyc++;
            got = ready2;
            if (!got) begin
                @(negedge CLK);
                req2 = ~req2;
                ADDR = 32'h4;
                WD   = 32'hDEAD0000 + 32'(cyc);
            end
        end
        req2 = 1'b0;
        check("toggle ready",   32'(got), 32'h1);
        check("toggle latency", cyc, 4);
        check("toggle tap",     32'(tv2), 32'h1234);
        fires = 0;
        @(posedge CLK);
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK);
            #1;
            if (ready2) fires++;
        end
        check("toggle no queue", fires, 0);
        $display("txn %-14s ws=2 cycles=%0d tap=0x%04h extra_ready=%0d", "req toggle", cyc, tv2, fires);
        txn("lw w1 keep", 0, 2'b10, 0, 32'h4, 32'h0, 32'h77777777, 0, 1);
        txn("lw w0 1234", 0, 2'b10, 0, 32'h0, 32'h0, 32'h00001234, 0, 1);

        // Same table against the zero-wait-state instance
        sel = 1'b1;
        #1;
        check("ws0 tap fresh", 32'(tv0), 32'h0);
        run_table();
        txn("ws0 sw 1234", 1, 2'b10, 0, 32'h0, 32'h00001234, 32'h0, 0, 0);
        #1;
        check("ws0 tap 1234", 32'(tv0), 32'h1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
